// File: rtl/btn_pkg.sv
// Shared state encoding and default timing constants for the push-button debouncer.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } btn_state_e;

  // 10 ms at 50 MHz
  localparam int unsigned BTN_DEBOUNCE_DEFAULT      = 500000;
  localparam int unsigned BTN_REPEAT_DELAY_DEFAULT  = 25000000;
  localparam int unsigned BTN_REPEAT_PERIOD_DEFAULT = 5000000;
  localparam int unsigned BTN_SIM_DEBOUNCE          = 4;

  function automatic int unsigned btn_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with synchronous active-high reset; reusable for any async level input.
module sync_2ff #(
  parameter int unsigned W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/button_debouncer.sv
// Debounces the raw push-button into a clean level plus one-cycle Rise/Fall strobes.
// Optional auto-repeat of Rise while held is enabled by defining BTN_AUTOREPEAT_EN.
module button_debouncer
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT
`ifdef BTN_AUTOREPEAT_EN
  , parameter int unsigned REPEAT_DELAY  = BTN_REPEAT_DELAY_DEFAULT
  , parameter int unsigned REPEAT_PERIOD = BTN_REPEAT_PERIOD_DEFAULT
`endif
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Button_raw,
  output logic Btn_level,
  output logic Rise,
  output logic Fall,
  output logic Busy
);

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned CNT_MAX = btn_max(DEBOUNCE_CYCLES, btn_max(REPEAT_DELAY, REPEAT_PERIOD));
`else
  localparam int unsigned CNT_MAX = DEBOUNCE_CYCLES;
`endif
  localparam int unsigned CNT_W = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             w_s;
  btn_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_level, w_level_nxt;
  logic             r_rise, w_rise_nxt;
  logic             r_fall, w_fall_nxt;

  sync_2ff #(.W(1)) u_sync (
    .i_clk (Clk),
    .i_rst (Rst),
    .i_d   (Button_raw),
    .o_q   (w_s)
  );

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] r_rep_cnt, w_rep_cnt_nxt;
  logic             r_rep_armed, w_rep_armed_nxt;
  logic [CNT_W-1:0] w_rep_last;

  // After the first repeat the counter reloads and compares against the shorter period.
  assign w_rep_last = r_rep_armed ? PER_LAST : DLY_LAST;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b0;
    end else begin
      r_rep_cnt   <= w_rep_cnt_nxt;
      r_rep_armed <= w_rep_armed_nxt;
    end
  end
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= IDLE_LOW;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    w_rep_cnt_nxt   = r_rep_cnt;
    w_rep_armed_nxt = r_rep_armed;
`endif
    case (r_state)
      IDLE_LOW: begin
        if (w_s) begin
          w_state_nxt = WAIT_HIGH;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!w_s) begin
          w_state_nxt = IDLE_LOW;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nxt = IDLE_HIGH;
          w_level_nxt = 1'b1;
          w_rise_nxt  = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
          w_rep_cnt_nxt   = '0;
          w_rep_armed_nxt = 1'b0;
`endif
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      IDLE_HIGH: begin
        if (!w_s) begin
          w_state_nxt = WAIT_LOW;
          w_cnt_nxt   = '0;
        end
`ifdef BTN_AUTOREPEAT_EN
        else if (r_rep_cnt == w_rep_last) begin
          w_rise_nxt      = 1'b1;
          w_rep_cnt_nxt   = '0;
          w_rep_armed_nxt = 1'b1;
        end else begin
          w_rep_cnt_nxt = r_rep_cnt + 1'b1;
        end
`endif
      end
      WAIT_LOW: begin
        if (w_s) begin
          w_state_nxt = IDLE_HIGH;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nxt = IDLE_LOW;
          w_level_nxt = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE_LOW;
    endcase
  end

  assign Btn_level = r_level;
  assign Rise      = r_rise;
  assign Fall      = r_fall;
  assign Busy      = (r_state == WAIT_HIGH) || (r_state == WAIT_LOW);

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Upstream stage of the single-step fetch path: turns the raw push-button into a clean, clock-synchronous level plus one-cycle Rise/Fall strobes.
- The fetch stage advances the PC on a Rise strobe, under the board clock, instead of being clocked by the raw bouncing button.
- Contents: a 2-flop synchronizer, a 4-state debounce FSM and a stability counter.

Parameters:
- DEBOUNCE_CYCLES, 500000, number of consecutive stable synchronized samples (10 ms at 50 MHz) needed to accept a new level; must be >= 2.
- REPEAT_DELAY, 25000000, cycles a press is held before the first auto-repeat strobe (used only with BTN_AUTOREPEAT_EN).
- REPEAT_PERIOD, 5000000, cycles between later auto-repeat strobes (used only with BTN_AUTOREPEAT_EN).
- CNT_W, derived localparam: $clog2 of the maximum of all counts used, plus 1.

Ports:
- Clk  in  1  board clock, rising-edge.
- Rst  in  1  reset, synchronous, active-high.
- Button_raw  in  1  asynchronous raw button, active-high.
- Btn_level  out  1  debounced button level.
- Rise  out  1  one-cycle strobe when a press is accepted (and on auto-repeat).
- Fall  out  1  one-cycle strobe when a release is accepted.
- Busy  out  1  high while in WAIT_HIGH or WAIT_LOW.

Behaviour:
- Reset (Rst sampled high at a Clk edge):
  - Sync flops = 0, state = IDLE_LOW, counter = 0.
  - Btn_level = 0, Rise = 0, Fall = 0, Busy = 0.
  - Reset overrides every other event in the same cycle.
- Synchronizer: s1 <= Button_raw; s <= s1. The FSM sees only s.
- IDLE_LOW: if s = 1, go to WAIT_HIGH and set counter to 0.
- WAIT_HIGH:
  - If s = 0, return to IDLE_LOW (bounce rejected, no strobe).
  - Else if counter = DEBOUNCE_CYCLES-1, go to IDLE_HIGH, set Btn_level <= 1 and Rise <= 1 for exactly one cycle.
  - Else counter++.
- IDLE_HIGH: if s = 0, go to WAIT_LOW and set counter to 0.
- WAIT_LOW:
  - If s = 1, return to IDLE_HIGH (no strobe).
  - Else if counter = DEBOUNCE_CYCLES-1, go to IDLE_LOW, set Btn_level <= 0 and Fall <= 1 for one cycle.
  - Else counter++.
- Latency:
  - Button_raw first sampled high at edge k and held stable: Rise is registered high at edge k+DEBOUNCE_CYCLES+2 and is low again after the next edge.
  - Fall has the same latency.
- Exclusivity: Rise and Fall are never high in the same cycle. Btn_level changes only in the cycle its strobe is asserted.
- Boundary conditions:
  - Glitch shorter than DEBOUNCE_CYCLES: no output change.
  - Counter never wraps; it saturates at the compare value.
  - Rst in a WAIT state aborts the pending acceptance with no strobe.
  - Button_raw held high through reset: after Rst drops, a normal Rise follows after DEBOUNCE_CYCLES+2 edges.
- Busy is a combinational decode of the state: high exactly in WAIT_HIGH and WAIT_LOW.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - In IDLE_HIGH a repeat counter (cleared on entry) counts held cycles.
  - At REPEAT_DELAY held cycles, Rise pulses for one cycle; after that, every REPEAT_PERIOD cycles.
  - Leaving IDLE_HIGH (to WAIT_LOW) freezes the repeat counter; returning from WAIT_LOW to IDLE_HIGH resumes it without a strobe. It is cleared only on entry from WAIT_HIGH.
  - Fall is unaffected.
- Undefined: exactly one Rise per accepted press. The repeat logic and the REPEAT_* parameters are absent from the netlist.

Decomposition:
- Shared package (btn_pkg):
  - 2-bit state encoding: IDLE_LOW = 0, WAIT_HIGH = 1, IDLE_HIGH = 2, WAIT_LOW = 3.
  - Default constants: 500000 cycles (10 ms at 50 MHz), the repeat defaults, and a simulation default of 4.
- Sub-module: sync_2ff (generic 2-flop synchronizer with synchronous reset), reusable for the Select switches.

Test Plan:
- Clean press, DEBOUNCE_CYCLES=4: Button_raw 0->1 sampled at edge 0 and held -> Rise high only in the cycle after edge 6; Btn_level = 1 from edge 6 on; Fall stays 0.
- Bounce rejection, DEBOUNCE_CYCLES=4: raw 1 for 3 cycles, 0 for 1, 1 for 2, 0 for 1, then 1 held from edge 10 -> no Rise before edge 16; single Rise at edge 16; Busy toggles during the bounces.
- Release: from IDLE_HIGH, raw 1->0 at edge 20 and held -> Fall pulse at edge 26, Btn_level = 0; a 2-cycle release glitch produces no Fall.
- Reset mid-wait: Rst=1 at edge 4 of a press (WAIT_HIGH) -> all outputs 0 at edge 5; raw kept high, Rst=0 at edge 7 -> Rise at edge 13.
- Auto-repeat (BTN_AUTOREPEAT_EN, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5): raw held high from edge 0 -> Rise at edges 6, 16, 21, 26; release -> single Fall, repeats stop.
- Macro undefined, same stimulus as the auto-repeat case -> exactly one Rise at edge 6.
